// File: rtl/requant_feeder.sv
// Requantizer from Q8.8 quantizer results to signed array operands. Each lane is rounded half-up, shifted and saturated.
// Converted rows are registered once, then held in a show-ahead FIFO that feeds the array loader over valid/ready.
module requant_feeder #(
  parameter int ARRAY_SIZE = 8,
  parameter int IN_WIDTH   = 16,
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*IN_WIDTH-1:0]   in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                             sat_sticky,
  input  logic                             sat_clear,
  output logic [$clog2(FIFO_DEPTH):0]      level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int OW = ARRAY_SIZE * DATA_WIDTH;
  localparam logic signed [IN_WIDTH:0] MAXV = (IN_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;

  logic [OW-1:0]         conv_data;
  logic [ARRAY_SIZE-1:0] lane_sat;
  logic                  s1_valid;
  logic [OW-1:0]         s1_data;
  logic [OW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // One extra bit of headroom keeps the rounding add from wrapping at the positive rail.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic signed [IN_WIDTH:0] xe;
    logic signed [IN_WIDTH:0] r;
    logic                     hi;
    logic                     lo;

    assign xe = {in_data[i*IN_WIDTH+IN_WIDTH-1], in_data[i*IN_WIDTH +: IN_WIDTH]};

    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [IN_WIDTH:0] RND = (IN_WIDTH+1)'(1 << (SHIFT-1));
      assign r = (xe + RND) >>> SHIFT;
    end else begin : g_pass
      assign r = xe;
    end

    assign hi = (r > MAXV);
    assign lo = (r < MINV);
    assign lane_sat[i] = hi | lo;
    assign conv_data[i*DATA_WIDTH +: DATA_WIDTH] =
      hi ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
      lo ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
           r[DATA_WIDTH-1:0];
  end

  // The row sitting in stage 1 is already committed to a FIFO slot, so it counts against space.
  assign in_ready  = (int'(level) + int'(s1_valid)) < FIFO_DEPTH;
  assign accept    = in_valid && in_ready;
  assign push      = s1_valid;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      sat_sticky <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= conv_data;
      end
      if (accept && (|lane_sat)) begin
        sat_sticky <= 1'b1;
      end else if (sat_clear) begin
        sat_sticky <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= s1_data;
    end
  end

endmodule

// File: tb/tb_requant_feeder.sv
// Bench for requant_feeder: fixed conversion vectors, hand-built corner sequences and randomized traffic.
// Expected rows, occupancy and the sticky flag all come from an arithmetic model of the block's behaviour.
module tb_requant_feeder;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         sat_sticky;
  logic         sat_clear;
  logic [2:0]   level;

  requant_feeder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_sticky(sat_sticky), .sat_clear(sat_clear), .level(level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: rows accepted but not yet taken, in order.
  logic [63:0] q[$];
  logic [7:0]  popped_tag[$];
  int          occ;
  logic        last_acc;
  logic        m_sticky;
  logic        stall_prev;
  logic [63:0] prev_data;
  int          acc_cnt;
  int          pop_cnt;

  typedef struct {
    logic [127:0] din;
    logic [63:0]  dout;
    logic         sat;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Round half up: floor((x + 8) / 16), then clamp to the signed 8-bit range.
  function automatic int lane_value(input logic [15:0] x);
    int v;
    v = int'($signed(x)) + 8;
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  function automatic logic [63:0] model_row(input logic [127:0] d);
    logic [63:0] r;
    int v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      v = lane_value(d[i*16 +: 16]);
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      r[i*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  function automatic logic model_sat(input logic [127:0] d);
    int v;
    for (int i = 0; i < 8; i++) begin
      v = lane_value(d[i*16 +: 16]);
      if (v > 127 || v < -128) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [127:0] rand_row();
    logic [127:0] d;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 0) d[i*16 +: 16] = 16'($urandom_range(0, 4095) - 2048);
      else d[i*16 +: 16] = 16'($urandom);
    end
    return d;
  endfunction

  function automatic logic [127:0] tag_row(input int t);
    logic [127:0] d;
    d = '0;
    d[15:0] = 16'(t * 16);
    return d;
  endfunction

  task automatic reset_model();
    q.delete();
    occ = 0; last_acc = 0; m_sticky = 0; stall_prev = 0; prev_data = '0;
  endtask

  // One clock: drive, check pre-edge state against the model, update the model, advance.
  task automatic cycle(input logic v, input logic [127:0] d, input logic ordy, input logic clr);
    logic acc;
    logic pop;
    in_valid = v; in_data = d; out_ready = ordy; sat_clear = clr;
    #1;
    chk("in_ready", 64'(in_ready), 64'(occ < DEPTH));
    chk("level", 64'(level), 64'(occ - int'(last_acc)));
    chk("out_valid", 64'(out_valid), 64'((occ - int'(last_acc)) != 0));
    chk("sat_sticky", 64'(sat_sticky), 64'(m_sticky));
    if (level > 3'(DEPTH)) chk("level_bound", 64'(level), 64'(DEPTH));
    if (!out_valid) chk("out_data_empty", out_data, 64'h0);
    if (stall_prev) chk("stall_stable", out_data, prev_data);
    acc = v && in_ready;
    pop = out_valid && ordy;
    if (pop) begin
      if (q.size() == 0) chk("pop_unexpected", 64'(1), 64'(0));
      else chk("out_data", out_data, q.pop_front());
      popped_tag.push_back(out_data[7:0]);
      pop_cnt++;
    end
    if (acc) begin
      q.push_back(model_row(d));
      acc_cnt++;
    end
    if (acc && model_sat(d)) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
    occ = occ + int'(acc) - int'(pop);
    last_acc = acc;
    stall_prev = out_valid && !ordy;
    prev_data = out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int cyc;
    tbl[0] = '{ {64'h0, 16'hFFF8, 16'h0008, 16'hFFE8, 16'h0128},
                {32'h0, 8'h00, 8'h01, 8'hFF, 8'h13}, 1'b0 };
    tbl[1] = '{ {64'h0, 16'hF808, 16'h07F7, 16'h8000, 16'h7FFF},
                {32'h0, 8'h81, 8'h7F, 8'h80, 8'h7F}, 1'b1 };
    tbl[2] = '{ {64'h0, 16'hF807, 16'h07F8, 16'hFFF7, 16'h0018},
                {32'h0, 8'h80, 8'h7F, 8'hFF, 8'h02}, 1'b1 };
    tbl[3] = '{ {16'h0007, 16'hFFF9, 16'h0010, 16'hFFF0, 16'h0017, 16'h0008, 16'hFFF7, 16'h0000},
                {8'h00, 8'h00, 8'h01, 8'hFF, 8'h01, 8'h01, 8'hFF, 8'h00}, 1'b0 };

    rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 0; sat_clear = 0;
    acc_cnt = 0; pop_cnt = 0;
    reset_model();
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_sticky", 64'(sat_sticky), 64'(0));
    rst = 1'b0;

    // Conversion vectors: accept, one bubble, head valid on the second edge.
    for (int i = 0; i < 4; i++) begin
      cycle(1, tbl[i].din, 0, 0);
      cycle(0, '0, 0, 0);
      chk("tbl_valid", 64'(out_valid), 64'(1));
      chk("tbl_data", out_data, tbl[i].dout);
      chk("tbl_sat", 64'(sat_sticky), 64'(tbl[i].sat));
      cycle(0, '0, 1, 1);
      chk("tbl_cleared", 64'(sat_sticky), 64'(0));
    end

    // Clear coinciding with a saturating accept: set wins.
    cycle(1, tbl[1].din, 0, 0);
    cycle(1, tbl[1].din, 0, 1);
    chk("set_wins", 64'(sat_sticky), 64'(1));
    cycle(1, tbl[0].din, 0, 1);
    chk("clear_nonsat", 64'(sat_sticky), 64'(0));
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0);

    // Backpressure with tagged rows 1..6.
    popped_tag.delete();
    t = 1;
    for (int i = 0; i < 8; i++) begin
      cycle(t <= 6, tag_row(t), 0, 0);
      if (last_acc) t++;
    end
    chk("bp_accepted", 64'(t - 1), 64'(4));
    chk("bp_level", 64'(level), 64'(4));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    cyc = 0;
    while ((t <= 6 || occ != 0) && cyc < 40) begin
      cycle(t <= 6, tag_row(t), 1, 0);
      if (last_acc) t++;
      cyc++;
    end
    chk("bp_drain_count", 64'(popped_tag.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < popped_tag.size()) chk("bp_order", 64'(popped_tag[i]), 64'(i + 1));
    end

    // Streaming: 20 rows back to back with the consumer always ready.
    acc_cnt = 0; pop_cnt = 0;
    for (int i = 0; i < 20; i++) cycle(1, rand_row(), 1, 0);
    chk("stream_accepts", 64'(acc_cnt), 64'(20));
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    chk("stream_pops", 64'(pop_cnt), 64'(20));

    // Random valid/ready toggling over 1000 rows.
    acc_cnt = 0; cyc = 0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      cycle($urandom_range(0, 3) != 0, rand_row(), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      cyc++;
    end
    chk("rand_accepts", 64'(acc_cnt), 64'(1000));
    for (int i = 0; i < 8; i++) cycle(0, '0, 1, 0);
    chk("rand_drained", 64'(q.size()), 64'(0));

    // Reset while three rows are buffered and one is in stage 1.
    for (int i = 0; i < 4; i++) cycle(1, rand_row(), 0, 0);
    chk("pre_rst_level", 64'(level), 64'(3));
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_level", 64'(level), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    cycle(0, '0, 1, 0);
    cycle(1, tbl[3].din, 0, 0);
    cycle(0, '0, 0, 0);
    chk("post_rst_valid", 64'(out_valid), 64'(1));
    chk("post_rst_data", out_data, tbl[3].dout);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
